// File: rtl/seg_scan_driver.sv
// Time-multiplexed 7-segment driver: one shared segment bus, one-hot digit selects,
// per-scan input snapshot, leading-zero blanking and inter-digit blanking.
module seg_scan_driver #(
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned BLANK_CYC  = 2,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     dig_en,
  input  logic                  blank_lz,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     dig_sel
);

  localparam int unsigned CntW = $clog2(SCAN_DIV);
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [7:0]        SegOff = ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] SelOff = ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [4*DIGITS-1:0] val_q;
  logic [DIGITS-1:0]   dp_q, en_q;
  logic                blz_q;
  logic [7:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   sel_q, sel_d;
  logic                snap_load;
  logic                slot_last;
  logic [DIGITS-1:0]   lz_mask;
  logic [3:0]          cur_nib;
  logic                cur_dp, cur_en, cur_lz;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] s;
    unique case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
    endcase
    return s;
  endfunction

  // Prescaler and digit index
  always_comb begin
    slot_last = (cnt_q == CntW'(SCAN_DIV - 1));
    cnt_d     = slot_last ? '0 : cnt_q + CntW'(1);
    idx_d     = idx_q;
    if (slot_last) begin
      idx_d = (idx_q == IdxW'(DIGITS - 1)) ? '0 : idx_q + IdxW'(1);
    end
    snap_load = (cnt_q == '0) && (idx_q == '0);
  end

  // A digit is a leading zero when it and every more significant nibble are zero.
  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    lz_mask  = '0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      zero_run   = zero_run & (val_q[4*i +: 4] == 4'h0);
      lz_mask[i] = blz_q & zero_run & (i != 0);
    end
  end

  always_comb begin
    cur_nib = '0;
    cur_dp  = 1'b0;
    cur_en  = 1'b0;
    cur_lz  = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (idx_q == IdxW'(i)) begin
        cur_nib = val_q[4*i +: 4];
        cur_dp  = dp_q[i];
        cur_en  = en_q[i];
        cur_lz  = lz_mask[i];
      end
    end
    seg_d = '0;
    sel_d = '0;
    if ((cnt_q >= CntW'(BLANK_CYC)) && cur_en) begin
      sel_d = DIGITS'(1) << idx_q;
      seg_d = {cur_dp, cur_lz ? 7'h00 : decode(cur_nib)};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
      val_q <= '0;
      dp_q  <= '0;
      en_q  <= '0;
      blz_q <= 1'b0;
      seg_q <= SegOff;
      sel_q <= SelOff;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      if (snap_load) begin
        val_q <= value;
        dp_q  <= dp;
        en_q  <= dig_en;
        blz_q <= blank_lz;
      end
      seg_q <= seg_d ^ SegOff;
      sel_q <= sel_d ^ SelOff;
    end
  end

  assign seg     = seg_q;
  assign dig_sel = sel_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: two instances (active-high and active-low) driven with
// directed and random stimulus, checked against a time-indexed behavioural model.
module tb_seg_scan_driver;

  localparam int unsigned ND = 4;
  localparam int unsigned SD = 4;
  localparam int unsigned BC = 1;
  localparam int          SCAN_LEN = int'(SD * ND);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = '0;
  logic [3:0]  dp = '0;
  logic [3:0]  dig_en = '0;
  logic        blank_lz = 1'b0;
  logic [7:0]  seg0, seg1;
  logic [3:0]  sel0, sel1;

  int n_cmp = 0;
  int n_fail = 0;

  // Model state: pos = cycles elapsed since the last reset edge.
  int          pos = 0;
  logic [15:0] snap_v = '0;
  logic [3:0]  snap_dp = '0;
  logic [3:0]  snap_en = '0;
  logic        snap_b = 1'b0;
  logic [7:0]  exp_seg = '0;
  logic [3:0]  exp_sel = '0;
  logic [6:0]  seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seg_scan_driver #(.DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYC(BC), .ACTIVE_LOW(1'b0)) dut_hi (
    .clk(clk), .rst(rst), .value(value), .dp(dp), .dig_en(dig_en), .blank_lz(blank_lz),
    .seg(seg0), .dig_sel(sel0)
  );

  seg_scan_driver #(.DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYC(BC), .ACTIVE_LOW(1'b1)) dut_lo (
    .clk(clk), .rst(rst), .value(value), .dp(dp), .dig_en(dig_en), .blank_lz(blank_lz),
    .seg(seg1), .dig_sel(sel1)
  );

  always #5 clk = ~clk;

  // Active-high view of the display during cycle p of the scan, from the snapshot.
  function automatic logic [11:0] ref_out(input int p, input logic [15:0] v,
                                          input logic [3:0] d, input logic [3:0] e,
                                          input logic b);
    int c, i;
    logic [3:0] nib;
    logic lz;
    c = p % int'(SD);
    i = (p / int'(SD)) % int'(ND);
    if (c < int'(BC) || !e[i]) return 12'h000;
    nib = 4'(v >> (4 * i));
    lz  = b && (i > 0) && ((v >> (4 * i)) == 16'h0);
    return {d[i], lz ? 7'h00 : seg_tab[nib], 4'(1 << i)};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      pos     <= 0;
      snap_v  <= '0;
      snap_dp <= '0;
      snap_en <= '0;
      snap_b  <= 1'b0;
      exp_seg <= '0;
      exp_sel <= '0;
    end else begin
      {exp_seg, exp_sel} <= ref_out(pos, snap_v, snap_dp, snap_en, snap_b);
      if (pos % SCAN_LEN == 0) begin
        snap_v  <= value;
        snap_dp <= dp;
        snap_en <= dig_en;
        snap_b  <= blank_lz;
      end
      pos <= pos + 1;
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (seg0 !== 8'h00 || sel0 !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_hi: got seg=%h sel=%b, required seg=00 sel=0000", seg0, sel0);
    end
    n_cmp++;
    if (seg1 !== 8'hFF || sel1 !== 4'hF) begin
      n_fail++;
      $display("FAIL reset_lo: got seg=%h sel=%b, required seg=ff sel=1111", seg1, sel1);
    end
  endtask

  task automatic test_basic();
    value = 16'h1234; dp = 4'h0; dig_en = 4'hF; blank_lz = 1'b0;
    rst = 1'b0;
    for (int k = 1; k <= 2 * SCAN_LEN; k++) begin
      @(negedge clk);
      n_cmp++;
      if (seg0 !== exp_seg || sel0 !== exp_sel) begin
        n_fail++;
        $display("FAIL basic_hi k=%0d: got seg=%h sel=%b, required seg=%h sel=%b",
                 k, seg0, sel0, exp_seg, exp_sel);
      end
      n_cmp++;
      if ({seg1, sel1} !== ~{exp_seg, exp_sel}) begin
        n_fail++;
        $display("FAIL basic_lo k=%0d: got seg=%h sel=%b, required seg=%h sel=%b",
                 k, seg1, sel1, ~exp_seg, ~exp_sel);
      end
      if (k == 2 || k == 6) begin
        n_cmp++;
        if (seg0 !== ((k == 2) ? 8'h66 : 8'h4F) || sel0 !== ((k == 2) ? 4'b0001 : 4'b0010)) begin
          n_fail++;
          $display("FAIL basic_fixed k=%0d: got seg=%h sel=%b", k, seg0, sel0);
        end
      end
    end
  endtask

  task automatic test_lz();
    for (int phase = 0; phase < 3; phase++) begin
      blank_lz = 1'b1;
      value    = (phase == 1) ? 16'h0000 : 16'h0050;
      dp       = (phase == 2) ? 4'b0100 : 4'b0000;
      for (int k = 0; k < 2 * SCAN_LEN; k++) begin
        @(negedge clk);
        n_cmp++;
        if (seg0 !== exp_seg || sel0 !== exp_sel) begin
          n_fail++;
          $display("FAIL lz_hi phase=%0d k=%0d: got seg=%h sel=%b, required seg=%h sel=%b",
                   phase, k, seg0, sel0, exp_seg, exp_sel);
        end
        n_cmp++;
        if ({seg1, sel1} !== ~{exp_seg, exp_sel}) begin
          n_fail++;
          $display("FAIL lz_lo phase=%0d k=%0d: got seg=%h sel=%b", phase, k, seg1, sel1);
        end
      end
    end
    blank_lz = 1'b0; dp = 4'h0;
  endtask

  task automatic test_enable();
    value = 16'h1234; dig_en = 4'b1011;
    for (int k = 0; k < 3 * SCAN_LEN; k++) begin
      @(negedge clk);
      n_cmp++;
      if (seg0 !== exp_seg || sel0 !== exp_sel) begin
        n_fail++;
        $display("FAIL enable_hi k=%0d: got seg=%h sel=%b, required seg=%h sel=%b",
                 k, seg0, sel0, exp_seg, exp_sel);
      end
      n_cmp++;
      if ({seg1, sel1} !== ~{exp_seg, exp_sel}) begin
        n_fail++;
        $display("FAIL enable_lo k=%0d: got seg=%h sel=%b", k, seg1, sel1);
      end
    end
    dig_en = 4'hF;
  endtask

  task automatic test_midscan();
    bit changed = 1'b0;
    value = 16'h1234;
    for (int k = 0; k < 4 * SCAN_LEN; k++) begin
      @(negedge clk);
      n_cmp++;
      if (seg0 !== exp_seg || sel0 !== exp_sel) begin
        n_fail++;
        $display("FAIL midscan k=%0d: got seg=%h sel=%b, required seg=%h sel=%b",
                 k, seg0, sel0, exp_seg, exp_sel);
      end
      if (!changed && k > SCAN_LEN && pos % SCAN_LEN == 9) begin
        value   = 16'hABCD;
        changed = 1'b1;
      end
    end
    n_cmp++;
    if (!changed) begin
      n_fail++;
      $display("FAIL midscan_trigger: got changed=0, required 1");
    end
  endtask

  task automatic test_reset_midscan();
    bit hit = 1'b0;
    value = 16'h1234; dig_en = 4'hF;
    for (int k = 0; k < 2 * SCAN_LEN && !hit; k++) begin
      @(negedge clk);
      if (pos % SCAN_LEN == 14) hit = 1'b1;
    end
    n_cmp++;
    if (!hit) begin
      n_fail++;
      $display("FAIL rst_mid_wait: got hit=0, required 1");
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (seg0 !== 8'h00 || sel0 !== 4'h0 || seg1 !== 8'hFF || sel1 !== 4'hF) begin
      n_fail++;
      $display("FAIL rst_mid: got seg=%h/%h sel=%b/%b, required 00/ff 0000/1111",
               seg0, seg1, sel0, sel1);
    end
    for (int k = 1; k <= SCAN_LEN; k++) begin
      @(negedge clk);
      n_cmp++;
      if (seg0 !== exp_seg || sel0 !== exp_sel) begin
        n_fail++;
        $display("FAIL rst_mid_scan k=%0d: got seg=%h sel=%b, required seg=%h sel=%b",
                 k, seg0, sel0, exp_seg, exp_sel);
      end
      if (k == 2) begin
        n_cmp++;
        if (seg0 !== 8'h66 || sel0 !== 4'b0001) begin
          n_fail++;
          $display("FAIL rst_mid_restart: got seg=%h sel=%b, required 66 0001", seg0, sel0);
        end
      end
    end
  endtask

  task automatic test_active_low();
    rst = 1'b1;
    value = 16'h1238; dp = 4'h0; dig_en = 4'hF; blank_lz = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (seg1 !== 8'hFF || sel1 !== 4'hF) begin
      n_fail++;
      $display("FAIL al_reset: got seg=%h sel=%b, required ff 1111", seg1, sel1);
    end
    rst = 1'b0;
    for (int k = 1; k <= SCAN_LEN; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({seg1, sel1} !== ~{exp_seg, exp_sel}) begin
        n_fail++;
        $display("FAIL al_scan k=%0d: got seg=%h sel=%b", k, seg1, sel1);
      end
      if (k == 2) begin
        n_cmp++;
        if (seg1 !== 8'h80 || sel1 !== 4'b1110) begin
          n_fail++;
          $display("FAIL al_digit0: got seg=%h sel=%b, required 80 1110", seg1, sel1);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 7) == 0) value = 16'($urandom);
      if ($urandom_range(0, 7) == 0) dp = 4'($urandom);
      if ($urandom_range(0, 7) == 0) dig_en = 4'($urandom);
      if ($urandom_range(0, 15) == 0) blank_lz = 1'($urandom);
      if ($urandom_range(0, 3) == 0) value[15:8] = 8'h00;
      rst = ($urandom_range(0, 79) == 0);
      @(negedge clk);
      n_cmp++;
      if (seg0 !== exp_seg || sel0 !== exp_sel) begin
        n_fail++;
        $display("FAIL random_hi k=%0d: got seg=%h sel=%b, required seg=%h sel=%b",
                 k, seg0, sel0, exp_seg, exp_sel);
      end
      n_cmp++;
      if ({seg1, sel1} !== ~{exp_seg, exp_sel}) begin
        n_fail++;
        $display("FAIL random_lo k=%0d: got seg=%h sel=%b", k, seg1, sel1);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lz();
    test_enable();
    test_midscan();
    test_reset_midscan();
    test_active_low();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
